// File: rtl/lsu_xlate_pkg.sv
// Shared types and helpers for the store/load address-translation sequencer.
// Latency: none (package only).
// Backpressure: n/a.
package lsu_xlate_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        REQ1  = 3'd2,
        MISS  = 3'd3,
        ISSUE = 3'd4,
        DRAIN = 3'd5
    } xlate_state_e;

    localparam logic [7:0] FAULT_MISS  = 8'h01;
    localparam logic [7:0] FAULT_WP    = 8'h02;
    localparam logic [7:0] FAULT_PRIV  = 8'h04;
    localparam logic [7:0] FAULT_PAGE2 = 8'h08;

    // Bits needed to name one bank inside a row.
    function automatic int bank_bits(input int bank_count);
        return $clog2(bank_count);
    endfunction

    // Bits of byte offset inside one row.
    function automatic int row_bits(input int bank_count, input int bank_bytes);
        return $clog2(bank_count * bank_bytes);
    endfunction

    // Index width that never collapses to zero (single-thread builds).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/saddr_bankmask.sv
// Bank-touch mask, row-split and page-cross flags for one access.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module saddr_bankmask
    import lsu_xlate_pkg::*;
#(
    parameter int BANK_COUNT = 32,
    parameter int BANK_BYTES = 4,
    parameter int PAGE_BITS  = 13
) (
    input  logic [PAGE_BITS-1:0]  voff_i,
    input  logic [2:0]            size_i,
    output logic [BANK_COUNT-1:0] banks_o,
    output logic                  split_o,
    output logic                  pcross_o
);

    localparam int BB_W  = $clog2(BANK_BYTES);
    localparam int BC_W  = bank_bits(BANK_COUNT);
    localparam int ROW_W = row_bits(BANK_COUNT, BANK_BYTES);
    localparam int EW    = PAGE_BITS + 1;

    logic [EW-1:0]   len_m1;
    logic [EW-1:0]   end_off;
    logic [BC_W-1:0] bank0;
    logic [BC_W-1:0] bank_e;
    logic [BC_W-1:0] span;
    logic [BC_W-1:0] rel;

    // Last byte offset; the extra top bit is the carry out of the page.
    always_comb begin
        len_m1   = (EW'(1) << size_i) - EW'(1);
        end_off  = {1'b0, voff_i} + len_m1;
        pcross_o = end_off[PAGE_BITS];
        split_o  = end_off[PAGE_BITS:ROW_W] != {1'b0, voff_i[PAGE_BITS-1:ROW_W]};
    end

    // Banks from bank0 up to the last byte's bank, wrapping modulo the row.
    always_comb begin
        bank0   = voff_i[BB_W +: BC_W];
        bank_e  = end_off[BB_W +: BC_W];
        span    = bank_e - bank0;
        rel     = '0;
        banks_o = '0;
        for (int i = 0; i < BANK_COUNT; i++) begin
            rel        = BC_W'(i) - bank0;
            banks_o[i] = (int'(size_i) >= ROW_W) || (rel <= span);
        end
    end

endmodule

// File: rtl/saddrcalc_xlate_seq.sv
// Address calc + one/two page MLB lookup sequencer with miss retry and fault checks.
// Latency: accept -> out_valid is 3 cycles for a 1-cycle TLB hit on a single page.
// Backpressure: in_ready only in IDLE; micro-op held stable until out_ready.
module saddrcalc_xlate_seq
    import lsu_xlate_pkg::*;
#(
    parameter int BANK_COUNT  = 32,
    parameter int BANK_BYTES  = 4,
    parameter int VADDR_WIDTH = 64,
    parameter int PADDR_WIDTH = 44,
    parameter int PAGE_BITS   = 13,
    parameter int THREADS     = 2,
    parameter int TAG_WIDTH   = 16,
    parameter int RETRY_MAX   = 3,
    localparam int TW    = idx_bits(THREADS),
    localparam int VPN_W = VADDR_WIDTH - PAGE_BITS,
    localparam int PPN_W = PADDR_WIDTH - PAGE_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [VADDR_WIDTH-1:0] in_vaddr_i,
    input  logic [2:0]             in_size_i,
    input  logic                   in_st_i,
    input  logic [TAG_WIDTH-1:0]   in_tag_i,
    input  logic [TW-1:0]          in_thread_i,
    input  logic [THREADS-1:0]     user_mode_i,
    input  logic                   flush_i,
    input  logic [TW-1:0]          flush_thread_i,
    output logic                   tlb_req_valid_o,
    output logic [VPN_W-1:0]       tlb_req_vpn_o,
    output logic [TW-1:0]          tlb_req_thread_o,
    input  logic                   tlb_rsp_valid_i,
    input  logic                   tlb_rsp_hit_i,
    input  logic [PPN_W-1:0]       tlb_rsp_ppn_i,
    input  logic                   tlb_rsp_wp_i,
    input  logic                   tlb_rsp_user_i,
    output logic                   mlb_miss_o,
    input  logic                   fill_done_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [PADDR_WIDTH-1:0] out_paddr0_o,
    output logic [PADDR_WIDTH-1:0] out_paddr1_o,
    output logic [BANK_COUNT-1:0]  out_banks_o,
    output logic                   out_split_o,
    output logic                   out_st_o,
    output logic [TAG_WIDTH-1:0]   out_tag_o,
    output logic                   out_fault_o,
    output logic [7:0]             out_fault_code_o
);

    localparam int ROW_W = row_bits(BANK_COUNT, BANK_BYTES);
    localparam int RF_W  = PAGE_BITS - ROW_W;
    localparam int RW    = idx_bits(RETRY_MAX + 1);

    xlate_state_e state_q, state_d;

    logic                   alive_q;
    logic                   miss_q;
    logic                   page_sel_q;
    logic [VADDR_WIDTH-1:0] vaddr_q;
    logic                   st_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [TW-1:0]          thread_q;
    logic [BANK_COUNT-1:0]  banks_q;
    logic                   split_q;
    logic                   pcross_q;
    logic [PPN_W-1:0]       ppn0_q;
    logic [PPN_W-1:0]       ppn1_q;
    logic [7:0]             code_q;
    logic [RW-1:0]          retry_q;

    logic [BANK_COUNT-1:0]  bm_banks;
    logic                   bm_split;
    logic                   bm_pcross;
    logic                   accept;
    logic                   kill;
    logic                   in_req;
    logic                   retry_lim;
    logic [7:0]             rsp_code;
    logic [RF_W-1:0]        next_row;

    saddr_bankmask #(
        .BANK_COUNT (BANK_COUNT),
        .BANK_BYTES (BANK_BYTES),
        .PAGE_BITS  (PAGE_BITS)
    ) u_bankmask (
        .voff_i   (in_vaddr_i[PAGE_BITS-1:0]),
        .size_i   (in_size_i),
        .banks_o  (bm_banks),
        .split_o  (bm_split),
        .pcross_o (bm_pcross)
    );

    // A flush of the requesting thread in the same cycle blocks the accept.
    assign accept    = in_valid_i && in_ready_o &&
                       !(flush_i && (flush_thread_i == in_thread_i));
    assign kill      = flush_i && (flush_thread_i == thread_q);
    assign in_req    = (state_q == REQ0) || (state_q == REQ1);
    assign retry_lim = (retry_q == RW'(RETRY_MAX));

    // Fault bits contributed by the lookup response seen this cycle.
    always_comb begin
        rsp_code = 8'h00;
        if (tlb_rsp_hit_i) begin
            if (st_q && tlb_rsp_wp_i)
                rsp_code = rsp_code | FAULT_WP;
            if (user_mode_i[thread_q] && !tlb_rsp_user_i)
                rsp_code = rsp_code | FAULT_PRIV;
        end else if (retry_lim) begin
            rsp_code = FAULT_MISS;
        end
        if ((rsp_code != 8'h00) && (state_q == REQ1))
            rsp_code = rsp_code | FAULT_PAGE2;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: lookup sequencing, miss/retry, flush kill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ0;
            end
            REQ0, REQ1: begin
                if (kill) begin
                    // A response landing this cycle leaves nothing to drain.
                    state_d = tlb_rsp_valid_i ? IDLE : DRAIN;
                end else if (tlb_rsp_valid_i) begin
                    if (tlb_rsp_hit_i)
                        state_d = ((state_q == REQ0) && pcross_q) ? REQ1 : ISSUE;
                    else if (retry_lim)
                        state_d = ISSUE;
                    else
                        state_d = MISS;
                end
            end
            MISS: begin
                if (kill)             state_d = IDLE;
                else if (fill_done_i) state_d = page_sel_q ? REQ1 : REQ0;
            end
            ISSUE: begin
                if (kill || out_ready_i) state_d = IDLE;
            end
            DRAIN: begin
                if (tlb_rsp_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Op context: latched at accept, translation results merged per response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alive_q    <= 1'b0;
            miss_q     <= 1'b0;
            page_sel_q <= 1'b0;
            vaddr_q    <= '0;
            st_q       <= 1'b0;
            tag_q      <= '0;
            thread_q   <= '0;
            banks_q    <= '0;
            split_q    <= 1'b0;
            pcross_q   <= 1'b0;
            ppn0_q     <= '0;
            ppn1_q     <= '0;
            code_q     <= 8'h00;
            retry_q    <= '0;
        end else begin
            alive_q <= 1'b1;
            miss_q  <= (state_d == MISS) && (state_q != MISS);
            if (in_req)
                page_sel_q <= (state_q == REQ1);
            if (accept) begin
                vaddr_q  <= in_vaddr_i;
                st_q     <= in_st_i;
                tag_q    <= in_tag_i;
                thread_q <= in_thread_i;
                banks_q  <= bm_banks;
                split_q  <= bm_split;
                pcross_q <= bm_pcross;
                ppn0_q   <= '0;
                ppn1_q   <= '0;
                code_q   <= 8'h00;
                retry_q  <= '0;
            end else if (in_req && tlb_rsp_valid_i && !kill) begin
                code_q <= code_q | rsp_code;
                if (tlb_rsp_hit_i) begin
                    if (state_q == REQ1) ppn1_q <= tlb_rsp_ppn_i;
                    else                 ppn0_q <= tlb_rsp_ppn_i;
                end else if (!retry_lim) begin
                    retry_q <= retry_q + RW'(1);
                end
            end
        end
    end

    // Outputs; data buses read zero whenever their valid is low.
    always_comb begin
        next_row         = vaddr_q[PAGE_BITS-1:ROW_W] + RF_W'(1);
        in_ready_o       = alive_q && (state_q == IDLE);
        tlb_req_valid_o  = in_req;
        tlb_req_vpn_o    = '0;
        tlb_req_thread_o = '0;
        if (in_req) begin
            tlb_req_vpn_o    = vaddr_q[VADDR_WIDTH-1:PAGE_BITS] + VPN_W'(state_q == REQ1);
            tlb_req_thread_o = thread_q;
        end
        mlb_miss_o       = miss_q;
        out_valid_o      = (state_q == ISSUE);
        out_paddr0_o     = '0;
        out_paddr1_o     = '0;
        out_banks_o      = '0;
        out_split_o      = 1'b0;
        out_st_o         = 1'b0;
        out_tag_o        = '0;
        out_fault_o      = 1'b0;
        out_fault_code_o = 8'h00;
        if (state_q == ISSUE) begin
            out_paddr0_o     = {ppn0_q, vaddr_q[PAGE_BITS-1:0]};
            // Next row wraps to offset 0 of the second page exactly when pcross.
            out_paddr1_o     = {(pcross_q ? ppn1_q : ppn0_q), next_row, ROW_W'(0)};
            out_banks_o      = banks_q;
            out_split_o      = split_q;
            out_st_o         = st_q;
            out_tag_o        = tag_q;
            out_fault_o      = |code_q;
            out_fault_code_o = code_q;
        end
    end

endmodule

// File: tb/tb_saddrcalc_xlate_seq.sv
module tb_saddrcalc_xlate_seq;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_vaddr;
    logic [2:0]  in_size;
    logic        in_st;
    logic [15:0] in_tag;
    logic        in_thread;
    logic [1:0]  user_mode;
    logic        flush;
    logic        flush_thread;
    logic        tlb_req_valid;
    logic [50:0] tlb_req_vpn;
    logic        tlb_req_thread;
    logic        tlb_rsp_valid;
    logic        tlb_rsp_hit;
    logic [30:0] tlb_rsp_ppn;
    logic        tlb_rsp_wp;
    logic        tlb_rsp_user;
    logic        mlb_miss;
    logic        fill_done;
    logic        out_valid;
    logic        out_ready;
    logic [43:0] out_paddr0;
    logic [43:0] out_paddr1;
    logic [31:0] out_banks;
    logic        out_split;
    logic        out_st;
    logic [15:0] out_tag;
    logic        out_fault;
    logic [7:0]  out_fault_code;

    saddrcalc_xlate_seq dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_vaddr_i       (in_vaddr),
        .in_size_i        (in_size),
        .in_st_i          (in_st),
        .in_tag_i         (in_tag),
        .in_thread_i      (in_thread),
        .user_mode_i      (user_mode),
        .flush_i          (flush),
        .flush_thread_i   (flush_thread),
        .tlb_req_valid_o  (tlb_req_valid),
        .tlb_req_vpn_o    (tlb_req_vpn),
        .tlb_req_thread_o (tlb_req_thread),
        .tlb_rsp_valid_i  (tlb_rsp_valid),
        .tlb_rsp_hit_i    (tlb_rsp_hit),
        .tlb_rsp_ppn_i    (tlb_rsp_ppn),
        .tlb_rsp_wp_i     (tlb_rsp_wp),
        .tlb_rsp_user_i   (tlb_rsp_user),
        .mlb_miss_o       (mlb_miss),
        .fill_done_i      (fill_done),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_paddr0_o     (out_paddr0),
        .out_paddr1_o     (out_paddr1),
        .out_banks_o      (out_banks),
        .out_split_o      (out_split),
        .out_st_o         (out_st),
        .out_tag_o        (out_tag),
        .out_fault_o      (out_fault),
        .out_fault_code_o (out_fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [50:0] vpn;
        logic        hit;
        logic [30:0] ppn;
        logic        wp;
        logic        user;
        int          lat;
    } tlbr_t;

    typedef struct {
        logic [43:0] p0;
        logic [43:0] p1;
        logic [31:0] banks;
        logic        split;
        logic        st;
        logic [15:0] tag;
        logic [7:0]  code;
    } exp_t;

    tlbr_t tlb_q[$];
    exp_t  exp_q[$];
    int checks = 0;
    int passes = 0;
    int n_req  = 0;
    int n_miss = 0;
    int n_outv = 0;
    int rise_cyc = 0;
    int acc_cyc  = 0;
    int fill_lat = 5;

    logic all_out_or;
    assign all_out_or = |{tlb_req_valid, tlb_req_vpn, tlb_req_thread, mlb_miss, out_valid,
                          out_paddr0, out_paddr1, out_banks, out_split, out_st, out_tag,
                          out_fault, out_fault_code};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic push_rsp(input logic [50:0] vpn, input logic hit, input logic [30:0] ppn,
                            input logic wp, input logic user, input int lat);
        tlbr_t r;
        r.vpn = vpn; r.hit = hit; r.ppn = ppn; r.wp = wp; r.user = user; r.lat = lat;
        tlb_q.push_back(r);
    endtask

    task automatic expect_out(input logic [43:0] p0, input logic [43:0] p1, input logic [31:0] banks,
                              input logic split, input logic st, input logic [15:0] tag,
                              input logic [7:0] code);
        exp_t e;
        e.p0 = p0; e.p1 = p1; e.banks = banks; e.split = split; e.st = st; e.tag = tag; e.code = code;
        exp_q.push_back(e);
    endtask

    // TLB model: one scripted response per new request, after r.lat cycles.
    initial begin
        tlbr_t r;
        tlb_rsp_valid = 1'b0; tlb_rsp_hit = 1'b0; tlb_rsp_ppn = '0;
        tlb_rsp_wp = 1'b0; tlb_rsp_user = 1'b0;
        forever begin
            @(negedge clk);
            if (tlb_req_valid && rst_ni) begin
                n_req++;
                if (tlb_q.size() == 0) begin
                    checks++;
                    $display("FAIL tlb_unexpected_req: actual vpn=%0h required no request", tlb_req_vpn);
                    @(posedge clk);
                end else begin
                    r = tlb_q.pop_front();
                    chk("tlb_req_vpn", 64'(tlb_req_vpn), 64'(r.vpn));
                    repeat (r.lat) @(posedge clk);
                    #1;
                    tlb_rsp_valid = 1'b1; tlb_rsp_hit = r.hit; tlb_rsp_ppn = r.ppn;
                    tlb_rsp_wp = r.wp; tlb_rsp_user = r.user;
                    @(posedge clk);
                    #1;
                    tlb_rsp_valid = 1'b0; tlb_rsp_hit = 1'b0;
                end
            end
        end
    end

    // Miss pulse counter.
    initial forever begin
        @(negedge clk);
        if (mlb_miss) n_miss++;
    end

    // Fill engine: completes a miss fill_lat cycles after the pulse.
    initial begin
        fill_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mlb_miss) begin
                repeat (fill_lat) @(posedge clk);
                #1 fill_done = 1'b1;
                @(posedge clk);
                #1 fill_done = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every delivered micro-op.
    initial begin
        exp_t e;
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) n_outv++;
            if (out_valid && !prev_v) rise_cyc = cyc;
            prev_v = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: actual tag=%0h required no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("paddr0", 64'(out_paddr0), 64'(e.p0));
                    if (e.split) chk("paddr1", 64'(out_paddr1), 64'(e.p1));
                    chk("banks", 64'(out_banks), 64'(e.banks));
                    chk("split", 64'(out_split), 64'(e.split));
                    chk("st_tag", 64'({out_st, out_tag}), 64'({e.st, e.tag}));
                    chk("fault", 64'(out_fault), 64'(|e.code));
                    chk("fault_code", 64'(out_fault_code), 64'(e.code));
                end
            end
        end
    end

    task automatic send(input logic [63:0] va, input logic [2:0] sz, input logic st,
                        input logic [15:0] tag, input logic thr);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_vaddr = va; in_size = sz; in_st = st; in_tag = tag; in_thread = thr;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 64'(in_ready), 64'(1));
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || tlb_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", 64'(n < 300), 64'(1));
    endtask

    int r0, m0, v0, n;

    initial begin
        rst_ni = 1'b0; in_valid = 1'b0; in_vaddr = '0; in_size = '0; in_st = 1'b0;
        in_tag = '0; in_thread = 1'b0; user_mode = 2'b00; flush = 1'b0; flush_thread = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_outputs", 64'(all_out_or), 64'(0));
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'(1));

        // 1: aligned word, single bank, latency and hold under backpressure
        push_rsp(51'h8000, 1, 31'h123, 0, 1, 1);
        expect_out(44'h246004, 44'h0, 32'h00000002, 0, 0, 16'h0001, 8'h00);
        out_ready = 1'b0;
        send(64'h10000004, 3'd2, 0, 16'h0001, 0);
        repeat (5) @(negedge clk);
        chk("t1_hold_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done();
        chk("t1_latency", 64'(rise_cyc - acc_cyc), 64'(3));

        // 2: row split with bank wrap, same page -> one lookup
        r0 = n_req;
        push_rsp(51'h0, 1, 31'h77, 0, 1, 1);
        expect_out(44'hEE07E, 44'hEE080, 32'h80000003, 1, 0, 16'h0002, 8'h00);
        send(64'h7E, 3'd3, 0, 16'h0002, 0);
        wait_done();
        chk("t2_req_count", 64'(n_req - r0), 64'(1));

        // 3: page cross -> two lookups, paddr1 from second page
        r0 = n_req;
        push_rsp(51'h0, 1, 31'h10, 0, 1, 1);
        push_rsp(51'h1, 1, 31'h20, 0, 1, 2);
        expect_out(44'h21FFC, 44'h40000, 32'h80000001, 1, 0, 16'h0003, 8'h00);
        send(64'h1FFC, 3'd3, 0, 16'h0003, 0);
        wait_done();
        chk("t3_req_count", 64'(n_req - r0), 64'(2));

        // 4a: one miss, fill after 5 cycles, retry hits
        m0 = n_miss; fill_lat = 5;
        push_rsp(51'h10000, 0, 31'h0, 0, 1, 1);
        push_rsp(51'h10000, 1, 31'h1, 0, 1, 1);
        expect_out(44'h2040, 44'h0, 32'h00010000, 0, 0, 16'h0004, 8'h00);
        send(64'h20000040, 3'd2, 0, 16'h0004, 0);
        wait_done();
        chk("t4_one_miss_pulse", 64'(n_miss - m0), 64'(1));

        // 4b: four misses in a row -> miss-limit fault
        m0 = n_miss; fill_lat = 2;
        for (int i = 0; i < 4; i++) push_rsp(51'h10000, 0, 31'h0, 0, 1, 1);
        expect_out(44'h40, 44'h0, 32'h00010000, 0, 0, 16'h0005, 8'h01);
        send(64'h20000040, 3'd2, 0, 16'h0005, 0);
        wait_done();
        chk("t4_three_pulses", 64'(n_miss - m0), 64'(3));

        // 5: write-protect, load to same page, privilege, second-page wp
        push_rsp(51'h2, 1, 31'h55, 1, 1, 1);
        expect_out(44'hAA000, 44'h0, 32'h00000001, 0, 1, 16'h0006, 8'h02);
        send(64'h4000, 3'd2, 1, 16'h0006, 0);
        wait_done();
        push_rsp(51'h2, 1, 31'h55, 1, 1, 1);
        expect_out(44'hAA000, 44'h0, 32'h00000001, 0, 0, 16'h0007, 8'h00);
        send(64'h4000, 3'd2, 0, 16'h0007, 0);
        wait_done();
        user_mode = 2'b10;
        push_rsp(51'h2, 1, 31'h55, 0, 0, 1);
        expect_out(44'hAA000, 44'h0, 32'h00000001, 0, 0, 16'h0008, 8'h04);
        send(64'h4000, 3'd2, 0, 16'h0008, 1);
        wait_done();
        user_mode = 2'b00;
        push_rsp(51'h0, 1, 31'h10, 0, 1, 1);
        push_rsp(51'h1, 1, 31'h20, 1, 1, 1);
        expect_out(44'h21FFC, 44'h40000, 32'h80000001, 1, 1, 16'h0009, 8'h0A);
        send(64'h1FFC, 3'd3, 1, 16'h0009, 0);
        wait_done();

        // 6: flush while the lookup is outstanding; response drained 2 cycles later
        v0 = n_outv;
        push_rsp(51'h2, 1, 31'h55, 0, 1, 2);
        send(64'h4000, 3'd2, 0, 16'h000A, 0);
        flush = 1'b1; flush_thread = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t6_drain_not_ready", 64'(in_ready), 64'(0));
        chk("t6_drain_no_req", 64'(tlb_req_valid), 64'(0));
        @(negedge clk);
        chk("t6_wait_rsp_not_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("t6_ready_after_rsp", 64'(in_ready), 64'(1));
        repeat (5) @(negedge clk);
        chk("t6_no_output", 64'(n_outv - v0), 64'(0));

        // 7: reset pulsed while waiting on a fill
        m0 = n_miss; fill_lat = 20;
        push_rsp(51'h2, 0, 31'h0, 0, 1, 1);
        send(64'h4000, 3'd2, 0, 16'h000B, 0);
        n = 0;
        while (n_miss == m0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t7_miss_seen", 64'(n_miss - m0), 64'(1));
        @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk("t7_rst_not_ready", 64'(in_ready), 64'(0));
        chk("t7_rst_outputs", 64'(all_out_or), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        v0 = n_outv;
        repeat (30) @(negedge clk);
        chk("t7_ready_after_rst", 64'(in_ready), 64'(1));
        chk("t7_no_output", 64'(n_outv - v0), 64'(0));

        // 8: normal operation after reset
        push_rsp(51'h8000, 1, 31'h123, 0, 1, 1);
        expect_out(44'h246004, 44'h0, 32'h00000002, 0, 0, 16'h000C, 8'h00);
        send(64'h10000004, 3'd2, 0, 16'h000C, 0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
